// File: rtl/vx_opc_dispatch.sv
// Operand dispatch: routes collector beats to per-unit 2-deep skid FIFOs, locking multi-beat instructions to one unit; `DISPATCH_PERF_EN adds perf_stalls.
// Latency: 1 cycle from accepted beat to out_valid when the target buffer was empty.
// Backpressure: in_ready depends only on the target buffer's registered fill, never on out_ready; out-of-range types are swallowed.

module vx_opc_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         vld,
  output logic         full,
  output logic [W-1:0] dat
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         rd_q, rd_d, wr_q, wr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    do_push = push && (cnt_q != 2'd2);
    do_pop  = pop && (cnt_q != 2'd0);
    if (do_push) begin
      mem_d[wr_q] = push_dat;
      wr_d        = ~wr_q;
    end
    if (do_pop) rd_d = ~rd_q;
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 2'd0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
    end
  end

  // Storage needs no reset: vld gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign vld  = (cnt_q != 2'd0);
  assign full = (cnt_q == 2'd2);
  assign dat  = mem_q[rd_q];
endmodule

module vx_opc_dispatch #(
  parameter int NUM_EX = 4,
  parameter int DATAW  = 256,
  parameter int EX_W   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATAW-1:0]        in_data,
  input  logic [EX_W-1:0]         in_ex_type,
  input  logic                    in_sop,
  input  logic                    in_eop,
  output logic [NUM_EX-1:0]       out_valid,
  input  logic [NUM_EX-1:0]       out_ready,
  output logic [NUM_EX*DATAW-1:0] out_data,
  output logic [NUM_EX-1:0]       out_sop,
  output logic [NUM_EX-1:0]       out_eop,
  output logic                    locked,
  output logic                    err
`ifdef DISPATCH_PERF_EN
  , output logic [15:0]           perf_stalls
`endif
);
  localparam int W = DATAW + 2;

  typedef struct packed {
    logic [DATAW-1:0] dat;
    logic             sop;
    logic             eop;
  } beat_t;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t            state_q, state_d;
  logic [EX_W-1:0]   unit_q, unit_d;
  logic              err_q, err_d;
  logic [EX_W-1:0]   sel;
  logic              sel_ok, sel_full, fire;
  logic [NUM_EX-1:0] full, push;
  beat_t             in_beat;
  beat_t             out_beat [NUM_EX];

  assign in_beat = {in_data, in_sop, in_eop};

  // unit_q is always in range, so sel_ok can only drop in IDLE.
  always_comb begin
    sel      = (state_q == ST_LOCKED) ? unit_q : in_ex_type;
    sel_ok   = 1'b0;
    sel_full = 1'b0;
    for (int i = 0; i < NUM_EX; i++) begin
      if (sel == EX_W'(i)) begin
        sel_ok   = 1'b1;
        sel_full = full[i];
      end
    end
    in_ready = !reset && (!sel_ok || !sel_full);
    fire     = in_valid && in_ready;
    for (int i = 0; i < NUM_EX; i++) begin
      push[i] = fire && (sel == EX_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    err_d   = err_q;
    if (fire) begin
      case (state_q)
        ST_IDLE: begin
          if (!sel_ok) begin
            err_d = 1'b1;
          end else begin
            if (!in_sop) err_d = 1'b1;
            if (in_sop && !in_eop) begin
              state_d = ST_LOCKED;
              unit_d  = in_ex_type;
            end
          end
        end
        ST_LOCKED: begin
          if ((in_ex_type != unit_q) || in_sop) err_d = 1'b1;
          if (in_eop) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      unit_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      err_q   <= err_d;
    end
  end

  assign locked = (state_q == ST_LOCKED);
  assign err    = err_q;

  for (genvar g = 0; g < NUM_EX; g++) begin : g_ex
    vx_opc_fifo2 #(.W(W)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push[g]),
      .push_dat (in_beat),
      .pop      (out_ready[g]),
      .vld      (out_valid[g]),
      .full     (full[g]),
      .dat      (out_beat[g])
    );
    assign out_data[g*DATAW +: DATAW] = out_beat[g].dat;
    assign out_sop[g]                 = out_beat[g].sop;
    assign out_eop[g]                 = out_beat[g].eop;
  end

`ifdef DISPATCH_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= 16'd0;
    else       stall_q <= stall_d;
  end

  assign perf_stalls = stall_q;
`endif
endmodule
